// File: rtl/ex_pkg.sv
// ex_pkg: ALU opcodes, multiplier FSM states and default opcode width for the execute stage
// No ports; imported by ex_iter_mul, ex_mem_stage_param and its interface.
package ex_pkg;
  localparam int OP_W_DEF = 4;
  localparam logic [OP_W_DEF-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W_DEF-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W_DEF-1:0] OP_AND = 4'd2;
  localparam logic [OP_W_DEF-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W_DEF-1:0] OP_SLT = 4'd4;
  localparam logic [OP_W_DEF-1:0] OP_XOR = 4'd5;
  localparam logic [OP_W_DEF-1:0] OP_NOR = 4'd6;
  localparam logic [OP_W_DEF-1:0] OP_SLL = 4'd7;
  localparam logic [OP_W_DEF-1:0] OP_MUL = 4'd8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
endpackage

// File: rtl/ex_mem_stage_param_if.sv
// ex_mem_stage_param_if: ID/EX, MEM/WB and EX/MEM signal bundle of the execute stage
// master: upstream/downstream side (drives ID/EX, WB, stall/flush; reads EX/MEM, ex_busy)
// slave: the execute stage itself
interface ex_mem_stage_param_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OP_W = ex_pkg::OP_W_DEF
);
  logic in_valid, stall_in, flush;
  logic reg_write, alu_src, reg_dst, mem_write, mem_read, mem_to_reg;
  logic [OP_W-1:0] alu_op;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] data1, data2, sext_imm;
  logic wb_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic ex_busy;
  logic out_valid, out_zero, out_reg_write, out_mem_write, out_mem_read, out_mem_to_reg;
  logic [REG_AW-1:0] out_dst;
  logic [DATA_W-1:0] out_alu, out_store_data;
  modport master (
    output in_valid, stall_in, flush, reg_write, alu_src, reg_dst, mem_write, mem_read,
           mem_to_reg, alu_op, rs, rt, rd, data1, data2, sext_imm, wb_reg_write, wb_rd, wb_data,
    input  ex_busy, out_valid, out_zero, out_reg_write, out_mem_write, out_mem_read,
           out_mem_to_reg, out_dst, out_alu, out_store_data
  );
  modport slave (
    input  in_valid, stall_in, flush, reg_write, alu_src, reg_dst, mem_write, mem_read,
           mem_to_reg, alu_op, rs, rt, rd, data1, data2, sext_imm, wb_reg_write, wb_rd, wb_data,
    output ex_busy, out_valid, out_zero, out_reg_write, out_mem_write, out_mem_read,
           out_mem_to_reg, out_dst, out_alu, out_store_data
  );
endinterface

// File: rtl/ex_iter_mul.sv
// ex_iter_mul: iterative shift-add multiplier, one multiplier bit per cycle, DATA_W cycles
// Ports: clk, rst (async high); start (accept a, b in IDLE); abort (drop to IDLE from RUN/DONE);
// hold (stay in DONE); busy (RUN or DONE); done (DONE); p (low DATA_W bits of a*b, valid in DONE).
module ex_iter_mul
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic hold,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic busy,
  output logic done,
  output logic [DATA_W-1:0] p
);
  localparam int CW = $clog2(DATA_W);
  mul_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] mcand, mplier;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (start ? RUN : IDLE)
        : abort ? IDLE
        : state == RUN ? (cnt == CW'(DATA_W - 1) ? DONE : RUN)
        : hold ? DONE : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      p <= '0;
    end else if (state == IDLE && start) begin
      cnt <= '0;
      mcand <= a;
      mplier <= b;
      p <= '0;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      p <= p + (mplier[0] ? mcand : '0);
    end
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: rtl/ex_mem_stage_param.sv
// ex_mem_stage_param: execute stage with inline ALU, iterative multiplier and EX/MEM register
// Ports: clk, rst (async, active high); bus (slave modport) carries the ID/EX instruction,
// MEM/WB write-back for forwarding, stall_in/flush, ex_busy and the registered EX/MEM outputs.
// Macro EX_MEM_FORWARD_EN: defined forwards operands EX/MEM then MEM/WB; undefined uses raw data.
module ex_mem_stage_param
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OP_W = OP_W_DEF
) (
  input logic clk,
  input logic rst,
  ex_mem_stage_param_if.slave bus
);
`ifdef EX_MEM_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif
  logic [OP_W-1:0] op;
  logic [DATA_W-1:0] fa, fb, opb, res, prod, m_sd;
  logic [REG_AW-1:0] dst, m_dst;
  logic em_ok, wb_ok, is_mul, mul_start, abort, busy, done;
  logic m_rw, m_mw, m_mr, m_mtr;
  assign op = bus.alu_op;
  // a load in EX/MEM has no data yet, so it is never a forwarding source
  assign em_ok = FWD_EN && bus.out_valid && bus.out_reg_write && !bus.out_mem_read;
  assign wb_ok = FWD_EN && bus.wb_reg_write;
  assign fa = bus.rs == '0 ? bus.data1
            : em_ok && bus.out_dst == bus.rs ? bus.out_alu
            : wb_ok && bus.wb_rd == bus.rs ? bus.wb_data : bus.data1;
  assign fb = bus.rt == '0 ? bus.data2
            : em_ok && bus.out_dst == bus.rt ? bus.out_alu
            : wb_ok && bus.wb_rd == bus.rt ? bus.wb_data : bus.data2;
  assign opb = bus.alu_src ? bus.sext_imm : fb;
  assign dst = bus.reg_dst ? bus.rd : bus.rt;
  always_comb begin
    res = '0;
    case (op)
      OP_ADD: res = fa + opb;
      OP_SUB: res = fa - opb;
      OP_AND: res = fa & opb;
      OP_OR:  res = fa | opb;
      OP_SLT: res = DATA_W'($signed(fa) < $signed(opb));
      OP_XOR: res = fa ^ opb;
      OP_NOR: res = ~(fa | opb);
      OP_SLL: res = fa << opb[4:0];
      default: res = '0;
    endcase
  end
  assign is_mul = bus.in_valid && op == OP_MUL;
  assign mul_start = is_mul && !bus.flush && !busy;
  // a stalled flush is ignored and must be re-asserted
  assign abort = bus.flush && !bus.stall_in;
  assign bus.ex_busy = busy || is_mul;
  ex_iter_mul #(.DATA_W(DATA_W)) u_mul (
    .clk(clk), .rst(rst), .start(mul_start), .abort(abort), .hold(bus.stall_in),
    .a(fa), .b(opb), .busy(busy), .done(done), .p(prod)
  );
  always_ff @(posedge clk)
    if (mul_start) begin
      m_rw <= bus.reg_write;
      m_mw <= bus.mem_write;
      m_mr <= bus.mem_read;
      m_mtr <= bus.mem_to_reg;
      m_dst <= dst;
      m_sd <= fb;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_zero <= 1'b0;
      bus.out_reg_write <= 1'b0;
      bus.out_mem_write <= 1'b0;
      bus.out_mem_read <= 1'b0;
      bus.out_mem_to_reg <= 1'b0;
      bus.out_dst <= '0;
      bus.out_alu <= '0;
      bus.out_store_data <= '0;
    end else if (!bus.stall_in) begin
      if (bus.flush || mul_start || (busy && !done)) begin
        bus.out_valid <= 1'b0;
        bus.out_reg_write <= 1'b0;
        bus.out_mem_write <= 1'b0;
        bus.out_mem_read <= 1'b0;
        bus.out_mem_to_reg <= 1'b0;
      end else if (done) begin
        bus.out_valid <= 1'b1;
        bus.out_zero <= prod == '0;
        bus.out_reg_write <= m_rw;
        bus.out_mem_write <= m_mw;
        bus.out_mem_read <= m_mr;
        bus.out_mem_to_reg <= m_mtr;
        bus.out_dst <= m_dst;
        bus.out_alu <= prod;
        bus.out_store_data <= m_sd;
      end else begin
        bus.out_valid <= bus.in_valid;
        bus.out_zero <= res == '0;
        bus.out_reg_write <= bus.in_valid && bus.reg_write;
        bus.out_mem_write <= bus.in_valid && bus.mem_write;
        bus.out_mem_read <= bus.in_valid && bus.mem_read;
        bus.out_mem_to_reg <= bus.in_valid && bus.mem_to_reg;
        bus.out_dst <= dst;
        bus.out_alu <= res;
        bus.out_store_data <= fb;
      end
    end
endmodule

// File: tb/tb_ex_mem_stage_param.sv
// tb_ex_mem_stage_param: randomized and directed check of ex_mem_stage_param against a behavioural model
module tb_ex_mem_stage_param;
`ifdef EX_MEM_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct packed {
    logic v, rw, mw, mr, mtr, z;
    logic [4:0] dst;
    logic [31:0] alu, sd;
  } ex_t;
  logic clk, rst;
  int n_cmp, n_bad;
  ex_t e, mres;
  bit pend;
  int runs;
  ex_mem_stage_param_if #(.DATA_W(32), .REG_AW(5), .OP_W(4)) ifc();
  ex_mem_stage_param #(.DATA_W(32), .REG_AW(5), .OP_W(4)) dut (.clk(clk), .rst(rst), .bus(ifc));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] alum(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return ~(a | b);
      4'd7: return a << b[4:0];
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic [31:0] fwdm(input logic [4:0] src, input logic [31:0] raw);
    if (!FWD || src == 5'd0) return raw;
    if (e.v && e.rw && !e.mr && e.dst == src) return e.alu;
    if (ifc.wb_reg_write && ifc.wb_rd == src) return ifc.wb_data;
    return raw;
  endfunction
  task automatic compare();
    chk("ex_busy", 32'(ifc.ex_busy), 32'(pend || (ifc.in_valid && ifc.alu_op == 4'd8)));
    chk("out_valid", 32'(ifc.out_valid), 32'(e.v));
    chk("out_reg_write", 32'(ifc.out_reg_write), 32'(e.rw));
    chk("out_mem_write", 32'(ifc.out_mem_write), 32'(e.mw));
    chk("out_mem_read", 32'(ifc.out_mem_read), 32'(e.mr));
    chk("out_mem_to_reg", 32'(ifc.out_mem_to_reg), 32'(e.mtr));
    if (e.v) begin
      chk("out_alu", ifc.out_alu, e.alu);
      chk("out_zero", 32'(ifc.out_zero), 32'(e.z));
      chk("out_dst", 32'(ifc.out_dst), 32'(e.dst));
      chk("out_store_data", ifc.out_store_data, e.sd);
    end
  endtask
  task automatic model();
    logic [31:0] a, bq, ob, r;
    logic st;
    ex_t nx;
    if (rst) begin
      e = '0;
      pend = 0;
      return;
    end
    a = fwdm(ifc.rs, ifc.data1);
    bq = fwdm(ifc.rt, ifc.data2);
    ob = ifc.alu_src ? ifc.sext_imm : bq;
    st = !pend && ifc.in_valid && ifc.alu_op == 4'd8 && !ifc.flush;
    nx = e;
    if (!ifc.stall_in) begin
      if (ifc.flush || st || (pend && runs > 0)) begin
        nx.v = 0; nx.rw = 0; nx.mw = 0; nx.mr = 0; nx.mtr = 0;
      end else if (pend) nx = mres;
      else begin
        r = alum(ifc.alu_op, a, ob);
        nx.v = ifc.in_valid;
        nx.rw = ifc.in_valid && ifc.reg_write;
        nx.mw = ifc.in_valid && ifc.mem_write;
        nx.mr = ifc.in_valid && ifc.mem_read;
        nx.mtr = ifc.in_valid && ifc.mem_to_reg;
        nx.z = r == 0;
        nx.dst = ifc.reg_dst ? ifc.rd : ifc.rt;
        nx.alu = r;
        nx.sd = bq;
      end
    end
    if (pend) begin
      if (ifc.flush && !ifc.stall_in) pend = 0;
      else if (runs > 0) runs--;
      else if (!ifc.stall_in) pend = 0;
    end else if (st) begin
      pend = 1;
      runs = 32;
      r = a * ob;
      mres.v = 1; mres.rw = ifc.reg_write; mres.mw = ifc.mem_write;
      mres.mr = ifc.mem_read; mres.mtr = ifc.mem_to_reg; mres.z = r == 0;
      mres.dst = ifc.reg_dst ? ifc.rd : ifc.rt; mres.alu = r; mres.sd = bq;
    end
    e = nx;
  endtask
  task automatic step();
    @(negedge clk);
    compare();
    model();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    ifc.in_valid = 0; ifc.stall_in = 0; ifc.flush = 0; ifc.wb_reg_write = 0;
  endtask
  task automatic put(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                     input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic rw);
    ifc.in_valid = 1; ifc.alu_op = op; ifc.data1 = d1; ifc.data2 = d2;
    ifc.rs = s; ifc.rt = t; ifc.rd = d; ifc.reg_dst = 1; ifc.reg_write = rw; ifc.alu_src = 0;
    ifc.sext_imm = 0; ifc.mem_write = 0; ifc.mem_read = 0; ifc.mem_to_reg = 0;
    ifc.stall_in = 0; ifc.flush = 0; ifc.wb_reg_write = 0; ifc.wb_rd = 0; ifc.wb_data = 0;
  endtask
  initial begin
    int cnt;
    n_cmp = 0; n_bad = 0; e = '0; mres = '0; pend = 0; runs = 0;
    rst = 1;
    put(0, 0, 0, 0, 0, 0, 0);
    idle();
    step(); step();
    chk("rst_valid", 32'(ifc.out_valid), 0);
    chk("rst_alu", ifc.out_alu, 0);
    rst = 0;
    put(0, 5, 7, 1, 2, 3, 0); step();
    chk("add_alu", ifc.out_alu, 12);
    chk("add_dst", 32'(ifc.out_dst), 3);
    chk("add_valid", 32'(ifc.out_valid), 1);
    chk("add_zero", 32'(ifc.out_zero), 0);
    put(1, 20, 6, 1, 2, 4, 1); step();
    chk("sub_alu", ifc.out_alu, 14);
    put(2, 32'hFF, 32'h0F, 4, 2, 6, 1); step();
    chk("fwd_exmem", ifc.out_alu, FWD ? 32'd14 : 32'd15);
    put(0, 1, 2, 1, 2, 5, 1); step();
    put(3, 32'h100, 0, 5, 0, 7, 1);
    ifc.wb_reg_write = 1; ifc.wb_rd = 5; ifc.wb_data = 32'h40; step();
    chk("fwd_priority", ifc.out_alu, FWD ? 32'd3 : 32'h100);
    put(0, 9, 0, 1, 0, 0, 1); step();
    put(0, 100, 1, 0, 6, 2, 0);
    ifc.wb_reg_write = 1; ifc.wb_rd = 0; ifc.wb_data = 77; step();
    chk("fwd_r0", ifc.out_alu, 101);
    put(0, 1, 2, 3, 0, 2, 0);
    ifc.wb_reg_write = 1; ifc.wb_rd = 3; ifc.wb_data = 50; step();
    chk("fwd_wb", ifc.out_alu, FWD ? 32'd52 : 32'd3);
    put(4, 32'hFFFF_FFFF, 1, 1, 2, 3, 0); step();
    chk("slt_alu", ifc.out_alu, 1);
    put(1, 9, 9, 1, 2, 3, 0); step();
    chk("sub_zero", 32'(ifc.out_zero), 1);
    put(0, 1, 1, 1, 2, 3, 0); ifc.stall_in = 1; ifc.flush = 1; step();
    chk("stall_flush_valid", 32'(ifc.out_valid), 1);
    chk("stall_flush_zero", 32'(ifc.out_zero), 1);
    idle(); step();
    put(8, 32'hFFFF_FFFF, 3, 1, 2, 8, 1);
    #1;
    chk("mul_busy_comb", 32'(ifc.ex_busy), 1);
    step();
    idle();
    cnt = 0;
    while (ifc.ex_busy && cnt < 100) begin
      cnt++;
      step();
    end
    chk("mul_busy_cycles", cnt, 33);
    chk("mul_alu", ifc.out_alu, 32'hFFFF_FFFD);
    chk("mul_valid", 32'(ifc.out_valid), 1);
    step();
    chk("mul_one_cycle", 32'(ifc.out_valid), 0);
    put(8, 1234, 5678, 1, 2, 9, 1); step();
    idle();
    repeat (32) step();
    ifc.stall_in = 1;
    repeat (4) step();
    chk("mul_stall_busy", 32'(ifc.ex_busy), 1);
    chk("mul_stall_valid", 32'(ifc.out_valid), 0);
    ifc.stall_in = 0; step();
    chk("mul_release_alu", ifc.out_alu, 32'd7006652);
    chk("mul_release_busy", 32'(ifc.ex_busy), 0);
    put(8, 7, 7, 1, 2, 10, 1); step();
    idle();
    repeat (10) step();
    ifc.flush = 1; step();
    ifc.flush = 0;
    chk("mul_flush_busy", 32'(ifc.ex_busy), 0);
    repeat (40) step();
    chk("mul_flush_valid", 32'(ifc.out_valid), 0);
    put(8, 3, 4, 1, 2, 11, 1); step();
    idle();
    repeat (10) step();
    #2 rst = 1;
    #1;
    chk("rst_mid_valid", 32'(ifc.out_valid), 0);
    chk("rst_mid_busy", 32'(ifc.ex_busy), 0);
    chk("rst_mid_alu", ifc.out_alu, 0);
    e = '0; pend = 0;
    step();
    rst = 0;
    repeat (600) begin
      ifc.in_valid = !pend && ($urandom_range(0, 3) != 0);
      ifc.alu_op = ($urandom_range(0, 19) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      ifc.data1 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 15);
      ifc.data2 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 15);
      ifc.sext_imm = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 31);
      ifc.rs = 5'($urandom_range(0, 7));
      ifc.rt = 5'($urandom_range(0, 7));
      ifc.rd = 5'($urandom_range(0, 7));
      ifc.reg_dst = 1'($urandom_range(0, 1));
      ifc.alu_src = 1'($urandom_range(0, 1));
      ifc.reg_write = 1'($urandom_range(0, 1));
      ifc.mem_write = 1'($urandom_range(0, 1));
      ifc.mem_read = $urandom_range(0, 3) == 0;
      ifc.mem_to_reg = 1'($urandom_range(0, 1));
      ifc.stall_in = $urandom_range(0, 7) == 0;
      ifc.flush = $urandom_range(0, 9) == 0;
      ifc.wb_reg_write = 1'($urandom_range(0, 1));
      ifc.wb_rd = 5'($urandom_range(0, 7));
      ifc.wb_data = $urandom;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage_param.md
Name: ex_mem_stage_param

Overview:
- Parametrised execute stage plus EX/MEM pipeline register for the pipelined MIPS core.
- Keeps the existing forwarding and ALU path; adds a valid bit, downstream stall, flush, wider ALU opcode set and an iterative multi-cycle multiplier.
- The multiplier stalls upstream through ex_busy.
- Sits between ID/EX register and the data-memory stage.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-address width.
- OP_W, 4, ALU opcode width.

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  ID/EX holds a real instruction
- stall_in  input  1  MEM stage cannot accept; hold EX/MEM register
- flush  input  1  kill instruction in EX (branch resolved)
- reg_write, alu_src, reg_dst, mem_write, mem_read, mem_to_reg  input  1 each  control bits
- alu_op  input  OP_W  operation code
- rs, rt, rd  input  REG_AW  register specifiers
- data1, data2, sext_imm  input  DATA_W  register operands, extended immediate
- wb_reg_write  input  1  MEM/WB writes register file
- wb_rd  input  REG_AW  MEM/WB destination
- wb_data  input  DATA_W  MEM/WB write-back data
- ex_busy  output  1  multiplier occupied; upstream must hold ID/EX
- out_valid, out_zero, out_reg_write, out_mem_write, out_mem_read, out_mem_to_reg  output  1 each  registered
- out_dst  output  REG_AW  registered destination (reg_dst ? rd : rt)
- out_alu, out_store_data  output  DATA_W  registered result, forwarded rt value

Behaviour:
- Reset (async): every output 0, FSM IDLE, counter 0.
- alu_op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed, result 0/1), 5 XOR, 6 NOR, 7 SLL (B[4:0]), 8 MUL (low DATA_W bits of product), 9–15 result 0.
- Arithmetic wraps modulo 2^DATA_W.
- out_zero = (result == 0).
- Operand B = alu_src ? sext_imm : fwd_b.
- Forwarding, priority EX/MEM over MEM/WB, never from register 0:
  - EX/MEM source requires out_valid && out_reg_write && !out_mem_read && out_dst==src.
  - Else MEM/WB source requires wb_reg_write && wb_rd==src.
  - Else raw data.
- Single-cycle ops, latency 1: valid instruction presented at edge N appears on outputs after edge N.
- MUL FSM states IDLE, RUN, DONE:
  - IDLE→RUN when in_valid && alu_op==8 && !flush.
  - On entry: latch forwarded A, B and all control/dst; counter=0.
  - RUN: shift-add one bit per cycle; DATA_W cycles; then DONE.
  - DONE: load EX/MEM register when !stall_in; return to IDLE.
  - ex_busy=1 in RUN and DONE, and combinationally in IDLE while a MUL is presented.
  - Upstream holds ID/EX while ex_busy=1.
- EX/MEM register update priority:
  - stall_in: hold everything, including DONE result.
  - Else flush: out_valid and all control outputs 0; data may be don't-care.
  - Else FSM RUN, or IDLE accepting MUL: bubble (out_valid=0, controls 0).
  - Else DONE: latched MUL result.
  - Else capture current instruction; controls gated with in_valid.
- flush in RUN or DONE aborts the MUL: FSM→IDLE next edge, no result written.
- stall_in and flush together: stall wins; flush must be re-asserted.
- in_valid=0: out_valid=0, controls 0.

Optional Feature:
- Macro EX_MEM_FORWARD_EN.
- Defined: forwarding muxes as above.
- Undefined: operands are raw data1/data2; the wb_* ports remain but are unused. The hazard unit must stall instead.

Decomposition:
- Package ex_pkg: alu_op localparams (OP_ADD … OP_MUL), FSM state enum, OP_W default.
- One sub-module, ex_iter_mul: start/abort inputs, busy/done outputs, DATA_W-cycle shift-add core; owns counter and accumulator.
- Combinational ALU stays inline.

Test Plan:
- Reset mid-MUL (RUN, count 10): assert rst → all outputs 0, ex_busy 0 immediately.
- ADD data1=5, data2=7, reg_dst=1, rd=3 → next cycle out_alu=12, out_dst=3, out_valid=1, out_zero=0.
- Back-to-back SUB writing r4 then AND using rs=r4 → second instruction uses EX/MEM value. Also: same-register EX/MEM and MEM/WB hits → EX/MEM wins; rs=0 never forwarded.
- MUL 0xFFFF_FFFF×3 → ex_busy high 33 cycles, bubbles meanwhile, then out_alu=0xFFFF_FFFD one cycle.
- MUL with stall_in during DONE for 4 cycles → result held, ex_busy held, released on first non-stall edge. Flush in RUN → no result, FSM IDLE.
- SLT -1 vs 1 → out_alu=1; SUB 9−9 → out_zero=1. stall_in with flush → outputs held unchanged.
